master_slave_collect: RTL and testbench

- Parametrised successor of the single-channel two-section master/slave block.
- Collects one signed sample from each of CHANNELS slave inputs, qualified by per-channel sync flags, during SECTION_A.
- Emits their combined sum during SECTION_B through a valid/ready handshake, then restarts.
- Sits between several slave producers and one master consumer. Adds multi-channel capture, configurable width, a saturating mode and overflow reporting.

---
 rtl/master_slave_collect.sv | 113 +++++++++++
 tb/tb_master_slave_collect.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/master_slave_collect.sv
// Multi-channel slave collector: sums one signed sample per channel during SECTION_A,
// then presents the (optionally saturated) total to the master through valid/ready in SECTION_B.
module master_slave_collect #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4,
    parameter int SATURATE = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] s_in,
    input  logic [CHANNELS-1:0]       s_in_sync,
    output logic [CHANNELS-1:0]       s_in_ack,
    output logic [WIDTH-1:0]          s_out,
    output logic                      s_out_valid,
    input  logic                      s_out_ready,
    output logic                      section,
    output logic [CHANNELS-1:0]       capture_mask,
    output logic                      overflow
);

    // Headroom for CHANNELS full-scale samples plus a sign bit, so the sum never wraps internally.
    localparam int ACC_W = WIDTH + $clog2(CHANNELS) + 1;

    localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    typedef enum logic {
        SECTION_A = 1'b0,
        SECTION_B = 1'b1
    } section_t;

    section_t                 state;
    section_t                 next_state;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_next;
    logic signed [ACC_W-1:0]  sum_in;
    logic [CHANNELS-1:0]      new_caps;
    logic [CHANNELS-1:0]      mask_next;
    logic                     all_done;
    logic                     range_ovf;
    logic [WIDTH-1:0]         final_val;

    function automatic logic signed [ACC_W-1:0] sext(input logic [WIDTH-1:0] v);
        return {{(ACC_W-WIDTH){v[WIDTH-1]}}, v};
    endfunction

    // NOTE: combinational blocks use blocking '=' and assign every output a default first,
    // so the running sum reads top-to-bottom and no latch is inferred.
    always_comb begin
        new_caps = (state == SECTION_A) ? (s_in_sync & ~capture_mask) : '0;
        sum_in   = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (new_caps[c]) sum_in = sum_in + sext(s_in[c*WIDTH +: WIDTH]);
        end
        acc_next  = acc + sum_in;
        mask_next = capture_mask | new_caps;
        all_done  = &mask_next;
    end

    always_comb begin
        range_ovf = (acc_next > MAX_V) || (acc_next < MIN_V);
        final_val = acc_next[WIDTH-1:0];
        if (SATURATE != 0) begin
            if (acc_next > MAX_V)      final_val = MAX_V[WIDTH-1:0];
            else if (acc_next < MIN_V) final_val = MIN_V[WIDTH-1:0];
        end
    end

    // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= SECTION_A;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            SECTION_A: if (all_done)    next_state = SECTION_B;
            SECTION_B: if (s_out_ready) next_state = SECTION_A;
            default:                    next_state = SECTION_A;
        endcase
    end

    always_comb begin
        section     = (state == SECTION_B);
        s_out_valid = (state == SECTION_B);
    end

    // In SECTION_B new_caps is zero, so acc/mask hold until the handshake clears them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc          <= '0;
            capture_mask <= '0;
            s_in_ack     <= '0;
            s_out        <= '0;
            overflow     <= 1'b0;
        end else begin
            s_in_ack <= new_caps;
            if (state == SECTION_B && s_out_ready) begin
                acc          <= '0;
                capture_mask <= '0;
            end else begin
                acc          <= acc_next;
                capture_mask <= mask_next;
            end
            if (state == SECTION_A && all_done) begin
                s_out    <= final_val;
                overflow <= range_ovf;
            end
        end
    end

endmodule

// File: tb/tb_master_slave_collect.sv
// Bench for master_slave_collect: wrap and saturate 4-channel instances in lockstep against a
// round-level reference model, plus a CHANNELS=1 WIDTH=8 instance with directed handshakes.
module tb_master_slave_collect;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [127:0] s_in = '0;
    logic [3:0]   sync = '0;
    logic         ready = 1'b0;

    logic [3:0]  w_ack, s_ack, w_mask, s_mask;
    logic [31:0] w_out, s_out;
    logic        w_valid, s_valid, w_sec, s_sec, w_ovf, s_ovf;

    logic [7:0] c_in = '0;
    logic [0:0] c_sync = '0;
    logic       c_ready = 1'b0;
    logic [0:0] c_ack, c_mask;
    logic [7:0] c_out;
    logic       c_valid, c_sec, c_ovf;

    int total = 0;
    int bad   = 0;

    // Reference model: which channels are captured, the exact running sum, and the emitted result.
    int          vals[4];
    bit          m_sec;
    bit [3:0]    m_mask;
    longint      m_sum;
    logic [31:0] m_wrap, m_sat;
    bit          m_ovf;
    bit [3:0]    m_ack;

    always #5 clk = ~clk;

    master_slave_collect #(.WIDTH(32), .CHANNELS(4), .SATURATE(0)) u_wrap (
        .clk(clk), .rst(rst), .s_in(s_in), .s_in_sync(sync), .s_in_ack(w_ack),
        .s_out(w_out), .s_out_valid(w_valid), .s_out_ready(ready), .section(w_sec),
        .capture_mask(w_mask), .overflow(w_ovf));

    master_slave_collect #(.WIDTH(32), .CHANNELS(4), .SATURATE(1)) u_sat (
        .clk(clk), .rst(rst), .s_in(s_in), .s_in_sync(sync), .s_in_ack(s_ack),
        .s_out(s_out), .s_out_valid(s_valid), .s_out_ready(ready), .section(s_sec),
        .capture_mask(s_mask), .overflow(s_ovf));

    master_slave_collect #(.WIDTH(8), .CHANNELS(1), .SATURATE(0)) u_one (
        .clk(clk), .rst(rst), .s_in(c_in), .s_in_sync(c_sync), .s_in_ack(c_ack),
        .s_out(c_out), .s_out_valid(c_valid), .s_out_ready(c_ready), .section(c_sec),
        .capture_mask(c_mask), .overflow(c_ovf));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("w_section", w_sec, m_sec);
        check("s_section", s_sec, m_sec);
        check("w_valid", w_valid, m_sec);
        check("s_valid", s_valid, m_sec);
        check("w_ack", w_ack, m_ack);
        check("s_ack", s_ack, m_ack);
        check("w_mask", w_mask, m_mask);
        check("s_mask", s_mask, m_mask);
        check("w_out", w_out, m_wrap);
        check("s_out", s_out, m_sat);
        check("w_ovf", w_ovf, m_ovf);
        check("s_ovf", s_ovf, m_ovf);
    endtask

    task automatic model_reset();
        m_sec = 0; m_mask = 0; m_sum = 0; m_wrap = 0; m_sat = 0; m_ovf = 0; m_ack = 0;
    endtask

    // Drive one cycle of stimulus, advance the model by the round rules, then compare.
    task automatic step(input bit [3:0] sy, input bit rd);
        sync  = sy;
        ready = rd;
        s_in  = {vals[3], vals[2], vals[1], vals[0]};
        m_ack = '0;
        if (!m_sec) begin
            for (int c = 0; c < 4; c++) begin
                if (sy[c] && !m_mask[c]) begin
                    m_sum     += longint'(vals[c]);
                    m_mask[c] = 1'b1;
                    m_ack[c]  = 1'b1;
                end
            end
            if (m_mask == 4'hF) begin
                m_sec  = 1;
                m_wrap = m_sum[31:0];
                m_ovf  = (m_sum > 64'sd2147483647) || (m_sum < -64'sd2147483648);
                if (m_sum > 64'sd2147483647)       m_sat = 32'h7FFF_FFFF;
                else if (m_sum < -64'sd2147483648) m_sat = 32'h8000_0000;
                else                               m_sat = m_sum[31:0];
            end
        end else if (rd) begin
            m_sec = 0; m_mask = 0; m_sum = 0;
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic set_vals(input int v0, input int v1, input int v2, input int v3);
        vals[0] = v0; vals[1] = v1; vals[2] = v2; vals[3] = v3;
    endtask

    initial begin
        logic [7:0] v;
        int         hold;
        int         mode;
        model_reset();
        set_vals(0, 0, 0, 0);

        // Reset state, then idle cycles.
        #3;
        check_all();
        check("c_out_reset", c_out, 8'h00);
        check("c_valid_reset", c_valid, 1'b0);
        #4 rst = 1'b1;
        step(4'h0, 0);
        step(4'h0, 1);

        // Consecutive syncs 1,2,3,4 -> sum 10, then handshake.
        set_vals(1, 2, 3, 4);
        step(4'b0001, 0);
        step(4'b0010, 0);
        step(4'b0100, 0);
        step(4'b1000, 0);
        step(4'b0000, 1);

        // All four at once: 5 - 7 + 100 + 2 = 100.
        set_vals(5, -7, 100, 2);
        step(4'b1111, 0);
        step(4'b0000, 1);

        // Repeated ch1 sync ignored; syncs during SECTION_B with ready low are ignored.
        set_vals(0, 11, 0, 0);
        step(4'b0010, 0);
        set_vals(0, 99, 0, 0);
        step(4'b0010, 0);
        set_vals(20, 99, 30, -40);
        step(4'b1101, 0);
        for (int i = 0; i < 5; i++) begin
            set_vals(int'($urandom), int'($urandom), int'($urandom), int'($urandom));
            step(4'b1111, 0);
        end
        step(4'b0000, 1);

        // Positive and negative full-scale sums.
        set_vals(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        step(4'b1111, 0);
        check("pos_sat_const", s_out, 32'h7FFF_FFFF);
        check("pos_wrap_const", w_out, 32'hFFFF_FFFC);
        step(4'b0000, 1);
        set_vals(32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000);
        step(4'b1111, 0);
        check("neg_sat_const", s_out, 32'h8000_0000);
        check("neg_ovf_const", s_ovf, 1'b1);
        step(4'b0000, 1);

        // Asynchronous reset in the middle of SECTION_B.
        set_vals(3, 3, 3, 3);
        step(4'b1111, 0);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_all();
        #2 rst = 1'b1;
        step(4'b0000, 0);

        // Randomised rounds with extreme values mixed in and random ready.
        for (int i = 0; i < 300; i++) begin
            for (int c = 0; c < 4; c++) begin
                mode = $urandom_range(0, 3);
                if (mode == 0)      vals[c] = 32'h7FFF_FFFF;
                else if (mode == 1) vals[c] = 32'h8000_0000;
                else                vals[c] = int'($urandom);
            end
            step(4'($urandom_range(0, 15) & $urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end

        // Single-channel, 8-bit instance: capture one sample, emit, handshake.
        for (int i = 0; i < 8; i++) begin
            v    = (i == 0) ? 8'h81 : 8'($urandom);
            hold = (i == 0) ? 0 : i % 3;
            c_in    = v;
            c_sync  = 1'b1;
            c_ready = (hold == 0);
            @(posedge clk);
            #1;
            check("c_ack", c_ack, 1'b1);
            check("c_valid", c_valid, 1'b1);
            check("c_section", c_sec, 1'b1);
            check("c_mask", c_mask, 1'b1);
            check("c_out", c_out, v);
            check("c_ovf", c_ovf, 1'b0);
            for (int k = 0; k < hold; k++) begin
                c_ready = 1'b0;
                c_in    = 8'($urandom);
                @(posedge clk);
                #1;
                check("c_hold_valid", c_valid, 1'b1);
                check("c_hold_ack", c_ack, 1'b0);
                check("c_hold_out", c_out, v);
            end
            c_ready = 1'b1;
            @(posedge clk);
            #1;
            check("c_ret_section", c_sec, 1'b0);
            check("c_ret_valid", c_valid, 1'b0);
            check("c_ret_mask", c_mask, 1'b0);
            check("c_ret_ack", c_ack, 1'b0);
            check("c_ret_out", c_out, v);
            c_sync  = 1'b0;
            c_ready = 1'b0;
            @(posedge clk);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
